// File: rtl/aes_inv_sbox_unit_if.sv
// Byte bus for the AES inverse S-box unit.
// Master drives the byte and its qualifier; slave returns the substitutions.
interface aes_inv_sbox_unit_if;
    logic [7:0] in;
    logic       in_vld;
    logic [7:0] out;
    logic [7:0] out_q;
    logic       out_vld;

    modport master (
        output in,
        output in_vld,
        input  out,
        input  out_q,
        input  out_vld
    );

    modport slave (
        input  in,
        input  in_vld,
        output out,
        output out_q,
        output out_vld
    );
endinterface

// File: rtl/aes_inv_sbox_unit.sv
// AES InvSubBytes byte primitive.
// Combinational InvSbox plus a one-cycle registered copy with valid flag.
module aes_inv_sbox_unit (
    input  logic                 clk,
    input  logic                 rst_n,
    aes_inv_sbox_unit_if.slave   bus
);

    function automatic logic [7:0] gf_mul(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(
        input logic [7:0] v,
        input int unsigned n
    );
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    // a^254 == a^-1 in GF(2^8), and maps 0 to 0 without a special case
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] a2, a3, a6, a12, a15;
        logic [7:0] a30, a60, a120, a240, a252;
        a2   = gf_mul(a, a);
        a3   = gf_mul(a2, a);
        a6   = gf_mul(a3, a3);
        a12  = gf_mul(a6, a6);
        a15  = gf_mul(a12, a3);
        a30  = gf_mul(a15, a15);
        a60  = gf_mul(a30, a30);
        a120 = gf_mul(a60, a60);
        a240 = gf_mul(a120, a120);
        a252 = gf_mul(a240, a12);
        return gf_mul(a252, a2);
    endfunction

    logic [7:0] t;
    logic [7:0] sub;
    logic [7:0] out_q_r;
    logic       out_vld_r;

    always_comb begin
        t   = rotl(bus.in, 1) ^ rotl(bus.in, 3)
            ^ rotl(bus.in, 6) ^ 8'h05;
        sub = gf_inv(t);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q_r   <= 8'h00;
            out_vld_r <= 1'b0;
        end else begin
            out_vld_r <= bus.in_vld;
            if (bus.in_vld) out_q_r <= sub;
        end
    end

    assign bus.out     = sub;
    assign bus.out_q   = out_q_r;
    assign bus.out_vld = out_vld_r;

endmodule

// File: tb/tb_aes_inv_sbox_unit.sv
// Self-checking bench for aes_inv_sbox_unit.
// Golden InvSbox is derived by inverting the FIPS-197 forward S-box table.
module tb_aes_inv_sbox_unit;

    logic clk;
    logic rst_n;

    aes_inv_sbox_unit_if bus ();

    aes_inv_sbox_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,
        8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,
        8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,
        8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,
        8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,
        8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,
        8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,
        8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,
        8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,
        8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,
        8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,
        8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,
        8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,
        8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,
        8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,
        8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,
        8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    typedef struct {
        logic [7:0] in;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs [8];
    logic [7:0] inv [256];
    logic       seen [256];
    int         n_cmp;
    int         n_bad;
    int         n_distinct;

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp, input logic [7:0] x);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s in=%02h got=%02h want=%02h",
                     name, x, act, exp);
        end
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        vecs[0] = '{8'h00, 8'h52};
        vecs[1] = '{8'h01, 8'h09};
        vecs[2] = '{8'h52, 8'h48};
        vecs[3] = '{8'h63, 8'h00};
        vecs[4] = '{8'h7c, 8'h01};
        vecs[5] = '{8'h16, 8'hff};
        vecs[6] = '{8'hed, 8'h53};
        vecs[7] = '{8'hff, 8'h7d};
        for (int i = 0; i < 256; i++) begin
            inv[SBOX[i]] = 8'(i);
            seen[i] = 1'b0;
        end

        // Reset state; combinational path live during reset
        rst_n      = 1'b0;
        bus.in     = 8'h52;
        bus.in_vld = 1'b1;
        #2;
        chk("rst_out_q", bus.out_q, 8'h00, bus.in);
        chk("rst_out_vld", {7'd0, bus.out_vld}, 8'h00, bus.in);
        chk("rst_out_comb", bus.out, 8'h48, bus.in);
        edge_wait();
        chk("rst_hold_q", bus.out_q, 8'h00, bus.in);
        #3;
        rst_n = 1'b1;
        bus.in_vld = 1'b0;
        edge_wait();

        // Hand-computed spot vectors through both paths
        for (int i = 0; i < 8; i++) begin
            bus.in     = vecs[i].in;
            bus.in_vld = 1'b1;
            #1;
            chk("spot_out", bus.out, vecs[i].exp, vecs[i].in);
            edge_wait();
            chk("spot_out_q", bus.out_q, vecs[i].exp, vecs[i].in);
        end

        // Exhaustive back-to-back sweep
        for (int x = 0; x < 256; x++) begin
            bus.in     = 8'(x);
            bus.in_vld = 1'b1;
            #1;
            chk("sweep_out", bus.out, inv[x], 8'(x));
            seen[bus.out] = 1'b1;
            edge_wait();
            chk("sweep_out_q", bus.out_q, inv[x], 8'(x));
            chk("sweep_vld", {7'd0, bus.out_vld}, 8'h01, 8'(x));
        end
        n_distinct = 0;
        for (int i = 0; i < 256; i++)
            if (seen[i]) n_distinct++;
        n_cmp++;
        if (n_distinct != 256) begin
            n_bad++;
            $display("FAIL distinct got=%0d want=256", n_distinct);
        end

        // Round trip InvSbox(Sbox(x)) == x
        bus.in_vld = 1'b0;
        for (int x = 0; x < 256; x++) begin
            bus.in = SBOX[x];
            #1;
            chk("roundtrip", bus.out, 8'(x), SBOX[x]);
        end

        // Async reset between edges while out_q = 0x7D
        bus.in     = 8'hff;
        bus.in_vld = 1'b1;
        edge_wait();
        chk("pre_rst_q", bus.out_q, 8'h7d, bus.in);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_q", bus.out_q, 8'h00, bus.in);
        chk("async_rst_vld", {7'd0, bus.out_vld}, 8'h00, bus.in);
        chk("async_rst_comb", bus.out, 8'h7d, bus.in);
        #2;
        rst_n      = 1'b1;
        bus.in     = 8'h00;
        edge_wait();
        chk("post_rst_q", bus.out_q, 8'h52, bus.in);

        // Hold: in_vld low, in changing
        bus.in_vld = 1'b0;
        bus.in     = 8'h63;
        #1;
        chk("hold_comb0", bus.out, 8'h00, bus.in);
        edge_wait();
        chk("hold_q0", bus.out_q, 8'h52, bus.in);
        chk("hold_vld0", {7'd0, bus.out_vld}, 8'h00, bus.in);
        bus.in = 8'h7c;
        #1;
        chk("hold_comb1", bus.out, 8'h01, bus.in);
        edge_wait();
        chk("hold_q1", bus.out_q, 8'h52, bus.in);
        chk("hold_vld1", {7'd0, bus.out_vld}, 8'h00, bus.in);

        // Pipelining 00, 01, FF on consecutive cycles
        bus.in_vld = 1'b1;
        bus.in = 8'h00;
        edge_wait();
        chk("pipe_q0", bus.out_q, 8'h52, 8'h00);
        chk("pipe_vld0", {7'd0, bus.out_vld}, 8'h01, 8'h00);
        bus.in = 8'h01;
        edge_wait();
        chk("pipe_q1", bus.out_q, 8'h09, 8'h01);
        chk("pipe_vld1", {7'd0, bus.out_vld}, 8'h01, 8'h01);
        bus.in = 8'hff;
        edge_wait();
        chk("pipe_q2", bus.out_q, 8'h7d, 8'hff);
        chk("pipe_vld2", {7'd0, bus.out_vld}, 8'h01, 8'hff);
        bus.in_vld = 1'b0;
        edge_wait();
        chk("pipe_drain_vld", {7'd0, bus.out_vld}, 8'h00, bus.in);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aes_inv_sbox_unit.md
Name: aes_inv_sbox_unit

Overview:
AES inverse substitution box (InvSubBytes byte primitive, FIPS-197 InvSbox) for the decryption datapath.
- Maps one 8-bit input byte to its inverse-S-box image through a zero-latency combinational path.
- Also provides a one-cycle registered copy with a valid flag, for pipelined round logic.
- Exhaustively verifiable over all 256 input values.

Parameters:
None.

Ports:
clk  input  1  system clock; registered outputs update on the rising edge.
rst_n  input  1  asynchronous active-low reset.
in  input  8  byte to substitute.
in_vld  input  1  qualifies `in` for the registered path.
out  output  8  combinational InvSbox(in).
out_q  output  8  registered InvSbox(in), one cycle latency.
out_vld  output  1  registered copy of in_vld; high when out_q holds a valid result.

Behaviour:
- out = InvSbox(in), purely combinational.
  - Depends only on `in`.
  - Independent of clk, rst_n and in_vld.
  - Valid within the same cycle, including while reset is asserted.
- InvSbox definition:
  - Step 1, inverse affine transform: t = rotl(in,1) ^ rotl(in,3) ^ rotl(in,6) ^ 8'h05.
  - Step 2: out = multiplicative inverse of t in GF(2^8) modulo x^8+x^4+x^3+x+1.
  - The inverse of 8'h00 is defined as 8'h00.
- Implementation form is free: a 256-entry constant case table, or a GF(2^8)/composite-field inverter. The result must be bit-exact to FIPS-197 for all 256 inputs.
- The function is a bijection, and InvSbox(Sbox(x)) = x for every x.
- Registered path:
  - On each rising clk edge with rst_n high: out_q <= InvSbox(in) when in_vld = 1, otherwise out_q holds its value.
  - out_vld <= in_vld on every rising edge.
- Reset:
  - rst_n low asynchronously forces out_q = 8'h00 and out_vld = 0, immediately and independent of clk.
  - Reset asserted mid-stream discards the in-flight result.
  - After rst_n deasserts, the first capture occurs at the next rising edge.
- Latency:
  - out: 0 cycles.
  - out_q / out_vld: 1 cycle.
  - Back-to-back inputs are accepted every cycle, with no stall and no handshake backpressure.
- No X propagation: every 8-bit input value yields a defined output. No internal state other than out_q and out_vld.

Test Plan:
- Exhaustive sweep: drive in = 0x00..0xFF, one value per clock with in_vld = 1. Compare out the same cycle and out_q the next cycle against the 256-entry FIPS-197 golden table; any mismatch fails, reporting input, expected and actual. Spot values:
  - 0x00->0x52
  - 0x01->0x09
  - 0x52->0x48
  - 0x63->0x00
  - 0x7C->0x01
  - 0x16->0xFF
  - 0xED->0x53
  - 0xFF->0x7D
- Round trip: for all x, feed Sbox(x) -> out == x. Also confirm the 256 outputs are all distinct.
- Reset: assert rst_n low asynchronously between clock edges while out_q = 0x7D -> out_q = 0x00 and out_vld = 0 immediately; out still equals InvSbox(in).
- Hold: in_vld = 0 with in changing 0x63 -> 0x7C -> out follows combinationally, out_q keeps its previous value, out_vld = 0.
- Pipelining: in_vld = 1 with in = 0x00, 0x01, 0xFF on consecutive cycles -> out_q = 0x52, 0x09, 0x7D on the following cycles, with out_vld high throughout.
